sipo_byte_receiver: RTL and testbench
=====================================

# sipo_byte_receiver

Serial-in/parallel-out receiver that reassembles a byte from a bit stream produced by the 8-bit rotating register's shift-right or shift-left path. Sits at the receiving end of the board-level serial link: it frames on a start strobe, shifts in one bit per enable strobe in the selected direction, and presents the completed byte with a valid/acknowledge handshake. Drives LEDR/HEX display logic or a downstream consumer.

## Interface
- DATA_W, 8, data bits per frame (fixed at 8 for this lab; parameterised for the counter width)
- Clock  in  1  rising-edge clock for all state
- Reset  in  1  synchronous, active-high reset
- SerialIn  in  1  serial data bit, sampled when ShiftEn=1
- ShiftEn  in  1  bit strobe; one bit captured per cycle it is high in SHIFT
- Start  in  1  frame start; honoured only in IDLE
- DirRight  in  1  1 = LSB first (mirrors shift-right), 0 = MSB first; latched at Start
- DataAck  in  1  consumer acknowledge; clears DataValid
- DataOut  out  8  last completed byte
- DataValid  out  1  DataOut holds an unacknowledged byte
- Busy  out  1  high while in SHIFT
- Overrun  out  1  sticky: a frame completed while DataValid was still high
- ParityErr  out  1  parity result for DataOut, valid while DataValid=1

## Operation
- States: IDLE, SHIFT.
- IDLE: Start=1 → SHIFT; clear shift register and bit counter; latch DirRight. ShiftEn ignored.
- SHIFT: on each ShiftEn=1 cycle, DirRight latched 1: shreg <= {SerialIn, shreg[7:1]}; latched 0: shreg <= {shreg[6:0], SerialIn}. Counter increments.
- Frame length: 8 bits (9 with parity, see Configuration). On the edge capturing the final bit → IDLE, completed byte loaded to DataOut, DataValid set.
- Start during SHIFT ignored; DirRight changes mid-frame ignored.
- Handshake: DataValid stays high until a cycle with DataAck=1; DataAck with DataValid=0 has no effect.
- Completion while DataValid=1 and DataAck=0: new byte dropped, DataOut unchanged, Overrun set.
- Completion and DataAck in same cycle: new byte loaded, DataValid stays 1, Overrun unchanged.
- Overrun cleared only by Reset.
- Reset mid-frame: frame abandoned, no DataValid, state IDLE.

## Timing
- Reset values: DataOut=8'h00, DataValid=0, Busy=0, Overrun=0, ParityErr=0, counter=0, state IDLE.
- Busy high the cycle after Start is sampled in IDLE; low the cycle after final bit captured.
- Latency: DataValid and DataOut visible one cycle after the cycle with the final ShiftEn=1.
- Minimum frame: 1 Start cycle + 8 ShiftEn cycles; back-to-back Start accepted the cycle Busy falls (IDLE).
- DataValid falls one cycle after DataAck=1 sampled.
- All outputs registered; no combinational input-to-output path.

## Configuration
- PARITY_EN defined: frame is 8 data bits then one parity bit (not shifted into shreg). Even parity; ParityErr registered with DataValid as XOR of 8 data bits and parity bit. Dropped frames (overrun) do not update ParityErr.
- PARITY_EN undefined: 8-bit frame; ParityErr port present, tied 0.

## Structure
- Shared package sipo_pkg: state enum (IDLE, SHIFT), DATA_W=8, FRAME_LEN constant (8, or 9 under PARITY_EN), counter width.
- One sub-module: sipo_bit_counter (clear, enable, terminal-count flag at FRAME_LEN-1).
- Shift register, handshake and flags in top level.

## Test plan
- LSB-first: Start with DirRight=1, shift bits 1,0,1,1,0,0,1,0 → DataOut=8'h4D, DataValid=1 one cycle after 8th bit, Overrun=0.
- MSB-first: DirRight=0, same bit sequence → DataOut=8'hB2; DirRight toggled mid-frame has no effect.
- Gaps/ignored Start: ShiftEn low on alternate cycles, Start pulsed mid-frame → byte correct, Busy not retriggered.
- Overrun: receive 8'hA5 without ack, then 8'h3C → DataOut=8'hA5, Overrun=1; DataAck → DataValid=0, Overrun stays 1.
- Simultaneous: DataAck coincident with final bit of 8'h0F → DataOut=8'h0F, DataValid remains 1, Overrun=0.
- Reset mid-frame after 4 bits → all outputs reset values; fresh frame 8'hFF received correctly. With PARITY_EN: 8'h07 plus parity 1 → ParityErr=0; parity 0 → ParityErr=1.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and frame constants for the serial byte receiver.
// Optional parity bit per frame is enabled by defining PARITY_EN.
package sipo_pkg;

   localparam int unsigned DATA_W = 8;

`ifdef PARITY_EN
   localparam int unsigned FRAME_LEN = DATA_W + 1;
`else
   localparam int unsigned FRAME_LEN = DATA_W;
`endif

   localparam int unsigned CNT_W = $clog2(FRAME_LEN);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// Bit counter for one frame; last_c flags the final bit position of the frame.
module sipo_bit_counter
   import sipo_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic last_c
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign last_c = (count == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/sipo_byte_receiver.sv
// Serial-in/parallel-out byte receiver with valid/ack handshake and sticky overrun.
// Define PARITY_EN for a ninth, even-parity bit per frame checked into ParityErr.
module sipo_byte_receiver
   import sipo_pkg::*;
(
   input  logic              Clock,
   input  logic              Reset,
   input  logic              SerialIn,
   input  logic              ShiftEn,
   input  logic              Start,
   input  logic              DirRight,
   input  logic              DataAck,
   output logic [DATA_W-1:0] DataOut,
   output logic              DataValid,
   output logic              Busy,
   output logic              Overrun,
   output logic              ParityErr
);

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt_c;
   logic [DATA_W-1:0] byte_c;
   logic              dir;
   logic              strobe_c;
   logic              last_c;
   logic              done_c;
   logic              shift_c;
   logic              parity_c;
   logic              start_c;

   assign start_c  = (state == IDLE) && Start;
   assign strobe_c = (state == SHIFT) && ShiftEn;
   assign done_c   = strobe_c && last_c;

   assign shreg_nxt_c = dir ? {SerialIn, shreg[DATA_W-1:1]}
                            : {shreg[DATA_W-2:0], SerialIn};

   // With parity the last bit of the frame is checked, not shifted in.
`ifdef PARITY_EN
   assign shift_c  = strobe_c && !last_c;
   assign byte_c   = shreg;
   assign parity_c = ^{shreg, SerialIn};
`else
   assign shift_c  = strobe_c;
   assign byte_c   = shreg_nxt_c;
   assign parity_c = 1'b0;
`endif

   sipo_bit_counter u_bit_counter (
      .clk    (Clock),
      .rst    (Reset),
      .clear  (start_c),
      .enable (strobe_c),
      .last_c (last_c)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         shreg     <= '0;
         dir       <= 1'b0;
         DataOut   <= '0;
         DataValid <= 1'b0;
         Busy      <= 1'b0;
         Overrun   <= 1'b0;
         ParityErr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  state <= SHIFT;
                  shreg <= '0;
                  dir   <= DirRight;
                  Busy  <= 1'b1;
               end
            end
            SHIFT: begin
               if (shift_c) begin
                  shreg <= shreg_nxt_c;
               end
               if (done_c) begin
                  state <= IDLE;
                  Busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase

         // A completion coinciding with an ack replaces the byte; otherwise it is dropped.
         if (done_c) begin
            if (!DataValid || DataAck) begin
               DataOut   <= byte_c;
               DataValid <= 1'b1;
               ParityErr <= parity_c;
            end else begin
               Overrun <= 1'b1;
            end
         end else if (DataAck) begin
            DataValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_byte_receiver.sv
// Directed bench for sipo_byte_receiver: table of frames plus hand-written corner sequences.
module tb_sipo_byte_receiver;

   logic       clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic       shift_en;
   logic       start;
   logic       dir_right;
   logic       data_ack;
   logic [7:0] data_out;
   logic       data_valid;
   logic       busy;
   logic       overrun;
   logic       parity_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       dir;
      logic [7:0] seq;        // seq[7] is transmitted first
      logic       gap;
      logic       mid_start;
      logic       toggle;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   sipo_byte_receiver dut (
      .Clock     (clk),
      .Reset     (rst),
      .SerialIn  (serial_in),
      .ShiftEn   (shift_en),
      .Start     (start),
      .DirRight  (dir_right),
      .DataAck   (data_ack),
      .DataOut   (data_out),
      .DataValid (data_valid),
      .Busy      (busy),
      .Overrun   (overrun),
      .ParityErr (parity_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Start strobe, 8 data bits, and the parity bit when configured.
   task automatic send_frame(input logic dir, input logic [7:0] seq, input logic gap,
                             input logic mid_start, input logic toggle,
                             input logic ack_last, input logic par);
      start     = 1'b1;
      dir_right = dir;
      tick();
      start = 1'b0;
      chk("busy_after_start", 8'(busy), 8'h01);
      for (int i = 0; i < 8; i++) begin
         if (gap) begin
            shift_en = 1'b0;
            start    = mid_start && (i == 3);
            tick();
            start = 1'b0;
         end
         shift_en  = 1'b1;
         serial_in = seq[7-i];
         if (toggle) dir_right = ~dir;
`ifndef PARITY_EN
         if (i == 7) data_ack = ack_last;
`endif
         tick();
      end
`ifdef PARITY_EN
      serial_in = par;
      data_ack  = ack_last;
      tick();
`else
      if (par) serial_in = 1'b0;
`endif
      shift_en  = 1'b0;
      data_ack  = 1'b0;
      serial_in = 1'b0;
   endtask

   task automatic ack();
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; serial_in = 1'b0; shift_en = 1'b0; start = 1'b0;
      dir_right = 1'b0; data_ack = 1'b0;

      vecs[0] = '{dir: 1'b1, seq: 8'hB2, gap: 1'b0, mid_start: 1'b0, toggle: 1'b0, exp: 8'h4D};
      vecs[1] = '{dir: 1'b0, seq: 8'hB2, gap: 1'b0, mid_start: 1'b0, toggle: 1'b1, exp: 8'hB2};
      vecs[2] = '{dir: 1'b1, seq: 8'hB2, gap: 1'b1, mid_start: 1'b1, toggle: 1'b0, exp: 8'h4D};
      vecs[3] = '{dir: 1'b0, seq: 8'h5A, gap: 1'b1, mid_start: 1'b1, toggle: 1'b1, exp: 8'h5A};
      vecs[4] = '{dir: 1'b1, seq: 8'h01, gap: 1'b0, mid_start: 1'b0, toggle: 1'b1, exp: 8'h80};
      vecs[5] = '{dir: 1'b0, seq: 8'h01, gap: 1'b0, mid_start: 1'b0, toggle: 1'b0, exp: 8'h01};

      tick(); tick();
      rst = 1'b0;
      chk("rst_data_out", data_out, 8'h00);
      chk("rst_valid", 8'(data_valid), 8'h00);
      chk("rst_busy", 8'(busy), 8'h00);
      chk("rst_overrun", 8'(overrun), 8'h00);
      chk("rst_parity", 8'(parity_err), 8'h00);

      // Ack with nothing pending has no effect.
      ack();
      chk("idle_ack_valid", 8'(data_valid), 8'h00);

      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].dir, vecs[v].seq, vecs[v].gap, vecs[v].mid_start,
                    vecs[v].toggle, 1'b0, ^vecs[v].exp);
         chk($sformatf("vec%0d_out", v), data_out, vecs[v].exp);
         chk($sformatf("vec%0d_valid", v), 8'(data_valid), 8'h01);
         chk($sformatf("vec%0d_busy", v), 8'(busy), 8'h00);
         chk($sformatf("vec%0d_overrun", v), 8'(overrun), 8'h00);
         chk($sformatf("vec%0d_parity", v), 8'(parity_err), 8'h00);
         ack();
         chk($sformatf("vec%0d_acked", v), 8'(data_valid), 8'h00);
      end

      // Completion coinciding with ack replaces the pending byte.
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sim_first_out", data_out, 8'h3C);
      send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("sim_out", data_out, 8'h0F);
      chk("sim_valid", 8'(data_valid), 8'h01);
      chk("sim_overrun", 8'(overrun), 8'h00);
      ack();

      // Overrun: second frame dropped while first is unacknowledged, back-to-back.
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovr_first_out", data_out, 8'hA5);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovr_out", data_out, 8'hA5);
      chk("ovr_valid", 8'(data_valid), 8'h01);
      chk("ovr_flag", 8'(overrun), 8'h01);
      ack();
      chk("ovr_ack_valid", 8'(data_valid), 8'h00);
      chk("ovr_sticky", 8'(overrun), 8'h01);

      // Reset after 4 bits abandons the frame.
      start = 1'b1; dir_right = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         shift_en = 1'b1; serial_in = 1'b1;
         tick();
      end
      shift_en = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_out", data_out, 8'h00);
      chk("mid_rst_valid", 8'(data_valid), 8'h00);
      chk("mid_rst_busy", 8'(busy), 8'h00);
      chk("mid_rst_overrun", 8'(overrun), 8'h00);
      chk("mid_rst_parity", 8'(parity_err), 8'h00);
      send_frame(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ff_out", data_out, 8'hFF);
      chk("ff_valid", 8'(data_valid), 8'h01);
      ack();

`ifdef PARITY_EN
      send_frame(1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("par_good_out", data_out, 8'h07);
      chk("par_good_err", 8'(parity_err), 8'h00);
      ack();
      send_frame(1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("par_bad_err", 8'(parity_err), 8'h01);
      ack();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
